// File: rtl/cycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cycle_pkg
//   Shared types and helpers for the wash-cycle sequencer.
//   - mode_e   : 2-bit wash intensity code driven by the mode selector
//   - phase_e  : 3-bit phase code reported to display/actuator logic
//   - dur_cfg_t: phase lengths in 1 s ticks, built from the top-level parameters
//   - next_phase / phase_duration: phase order and the length loaded on entry
// -----------------------------------------------------------------------------
package cycle_pkg;

   typedef enum logic [1:0] {
      MODE_NONE = 2'b00,
      MODE_LOW  = 2'b01,
      MODE_NORM = 2'b10,
      MODE_HIGH = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      PH_IDLE  = 3'b000,
      PH_FILL  = 3'b001,
      PH_RUN   = 3'b010,
      PH_DRAIN = 3'b011,
      PH_DONE  = 3'b100
   } phase_e;

   typedef struct packed {
      logic [7:0] fill;
      logic [7:0] run_low;
      logic [7:0] run_norm;
      logic [7:0] run_high;
      logic [7:0] drain;
      logic [7:0] done;
   } dur_cfg_t;

   // Fixed phase order; DONE wraps back to IDLE.
   function automatic phase_e next_phase(input phase_e ph);
      phase_e nxt;
      case (ph)
         PH_FILL:  nxt = PH_RUN;
         PH_RUN:   nxt = PH_DRAIN;
         PH_DRAIN: nxt = PH_DONE;
         default:  nxt = PH_IDLE;
      endcase
      return nxt;
   endfunction

   // Length (ticks) loaded when a phase is entered. Only RUN depends on the
   // latched mode; IDLE reports zero time left.
   function automatic logic [7:0] phase_duration(input phase_e ph, input mode_e m,
                                                 input dur_cfg_t cfg);
      logic [7:0] dur;
      case (ph)
         PH_FILL: dur = cfg.fill;
         PH_RUN: begin
            case (m)
               MODE_LOW:  dur = cfg.run_low;
               MODE_NORM: dur = cfg.run_norm;
               MODE_HIGH: dur = cfg.run_high;
               default:   dur = 8'd0;
            endcase
         end
         PH_DRAIN: dur = cfg.drain;
         PH_DONE:  dur = cfg.done;
         default:  dur = 8'd0;
      endcase
      return dur;
   endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// cycle_sequencer_if
//   Mode-selector <-> sequencer link.
//   start : selector -> sequencer, level request to begin a cycle
//   mode  : selector -> sequencer, 2-bit wash mode (00 invalid)
//   idle  : sequencer -> selector, high while no cycle runs (mode may change)
//   pause : selector -> sequencer, only when CYCLE_PAUSE_EN is defined
// Modports: master = mode selector, slave = cycle_sequencer.
// -----------------------------------------------------------------------------
interface cycle_sequencer_if;
   logic       start;
   logic [1:0] mode;
   logic       idle;
`ifdef CYCLE_PAUSE_EN
   logic       pause;

   modport master (output start, output mode, output pause, input idle);
   modport slave  (input start, input mode, input pause, output idle);
`else
   modport master (output start, output mode, input idle);
   modport slave  (input start, input mode, output idle);
`endif
endinterface

// File: rtl/cycle_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Generates a one-clock strobe every DIV enabled clocks (the 1 s tick).
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : count enable; the counter holds its value while low
//   clr  : synchronous clear to 0 (takes priority over en)
//   tick : high for the enabled cycle on which the count is DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
   parameter int unsigned DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Gated by en so a stalled counter parked on LAST does not fire repeatedly.
   assign tick = en && (cnt_q == LAST);

   always_comb begin
      // NOTE: defaulting cnt_d to its current value first keeps every path
      // assigned, so no latch is inferred.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
//   Runs a timed wash cycle FILL -> RUN -> DRAIN -> DONE once started with a
//   valid mode, and reports phase, ticks left and a completion pulse.
//   Optional feature macro: CYCLE_PAUSE_EN (adds bus.pause, stalls counting).
// Ports
//   clk          : system clock, all logic on posedge
//   rst          : synchronous active-high reset
//   bus          : cycle_sequencer_if.slave (start, mode in; idle out; pause in)
//   phase_o      : 000 IDLE, 001 FILL, 010 RUN, 011 DRAIN, 100 DONE
//   run_mode_o   : mode latched at start, 00 while idle
//   time_left_o  : ticks remaining in the current phase, 0 in IDLE
//   cycle_done_o : one-clock pulse on the DONE -> IDLE transition
// -----------------------------------------------------------------------------
module cycle_sequencer
   import cycle_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned FILL_T   = 3,
   parameter int unsigned RUN_LOW  = 4,
   parameter int unsigned RUN_NORM = 6,
   parameter int unsigned RUN_HIGH = 8,
   parameter int unsigned DRAIN_T  = 2,
   parameter int unsigned DONE_T   = 2
) (
   input  logic                clk,
   input  logic                rst,
   cycle_sequencer_if.slave    bus,
   output logic [2:0]          phase_o,
   output logic [1:0]          run_mode_o,
   output logic [7:0]          time_left_o,
   output logic                cycle_done_o
);

   localparam dur_cfg_t CFG = '{
      fill:     8'(FILL_T),
      run_low:  8'(RUN_LOW),
      run_norm: 8'(RUN_NORM),
      run_high: 8'(RUN_HIGH),
      drain:    8'(DRAIN_T),
      done:     8'(DONE_T)
   };

   phase_e     phase_q;
   mode_e      run_mode_q;
   logic [7:0] time_left_q;
   logic       idle_q;
   logic       cycle_done_q;

   logic       busy;
   logic       hold;
   logic       tick;
   mode_e      mode_in;
   phase_e     phase_nxt;

   assign mode_in   = mode_e'(bus.mode);
   assign busy      = (phase_q != PH_IDLE);
   assign phase_nxt = next_phase(phase_q);

`ifdef CYCLE_PAUSE_EN
   // Pause only matters mid-cycle; in IDLE the prescaler is cleared anyway.
   assign hold = bus.pause;
`else
   assign hold = 1'b0;
`endif

   // Prescaler is parked at 0 whenever idle, so every cycle's first tick
   // lands exactly TICK_DIV clocks after start.
   tick_prescaler #(
      .DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (busy && !hold),
      .clr  (!busy),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q      <= PH_IDLE;
         run_mode_q   <= MODE_NONE;
         time_left_q  <= 8'd0;
         idle_q       <= 1'b1;
         cycle_done_q <= 1'b0;
      end else begin
         cycle_done_q <= 1'b0;
         if (!busy) begin
            if (bus.start && (mode_in != MODE_NONE)) begin
               phase_q     <= PH_FILL;
               run_mode_q  <= mode_in;
               time_left_q <= CFG.fill;
               idle_q      <= 1'b0;
            end
         end else if (tick) begin
            if (time_left_q > 8'd1) begin
               time_left_q <= time_left_q - 8'd1;
            end else begin
               // Last tick of the phase: move on and load the next length.
               phase_q     <= phase_nxt;
               time_left_q <= phase_duration(phase_nxt, run_mode_q, CFG);
               if (phase_nxt == PH_IDLE) begin
                  run_mode_q   <= MODE_NONE;
                  idle_q       <= 1'b1;
                  cycle_done_q <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.idle     = idle_q;
   assign phase_o      = phase_q;
   assign run_mode_o   = run_mode_q;
   assign time_left_o  = time_left_q;
   assign cycle_done_o = cycle_done_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cycle_sequencer
//   Directed scenarios plus randomized start/mode/reset (and pause when
//   CYCLE_PAUSE_EN is defined). A reference model tracks how many active clocks
//   have elapsed in the current cycle and derives phase and ticks left from
//   the cumulative phase lengths; it is compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_cycle_sequencer;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] phase;
   logic [1:0] run_mode;
   logic [7:0] time_left;
   logic       cycle_done;
   logic       pause_m;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   cycle_sequencer_if bus ();

   cycle_sequencer #(.TICK_DIV(TD)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .phase_o      (phase),
      .run_mode_o   (run_mode),
      .time_left_o  (time_left),
      .cycle_done_o (cycle_done)
   );

`ifdef CYCLE_PAUSE_EN
   assign pause_m = bus.pause;
`else
   assign pause_m = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   int m_busy = 0;
   int m_k    = 0;   // active (non-paused) clocks completed since start
   int m_lm   = 0;
   int m_done = 0;

   function automatic int run_ticks(input int m);
      return (m == 1) ? 4 : (m == 2) ? 6 : 8;
   endfunction

   function automatic int total_ticks(input int m);
      return 3 + run_ticks(m) + 2 + 2;
   endfunction

   always @(posedge clk) begin
      m_done = 0;
      if (rst) begin
         m_busy = 0; m_k = 0; m_lm = 0;
      end else if (m_busy == 0) begin
         if (bus.start && bus.mode != 2'b00) begin
            m_busy = 1; m_k = 0; m_lm = int'(bus.mode);
         end
      end else begin
         if (!pause_m) m_k++;
         if (m_k == total_ticks(m_lm) * TD) begin
            m_busy = 0; m_done = 1; m_lm = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int ep, etl, te, acc, i;
         int d[4];
         if (m_busy == 0) begin
            ep = 0; etl = 0;
         end else begin
            d[0] = 3; d[1] = run_ticks(m_lm); d[2] = 2; d[3] = 2;
            te = m_k / TD;
            acc = 0; i = 0;
            while (i < 3 && te >= acc + d[i]) begin
               acc += d[i];
               i++;
            end
            ep  = i + 1;
            etl = d[i] - (te - acc);
         end
         check("phase",      phase,      ep);
         check("time_left",  time_left,  etl);
         check("run_mode",   run_mode,   m_lm);
         check("idle",       bus.idle,   (m_busy == 0));
         check("cycle_done", cycle_done, m_done);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic run_one(input logic [1:0] m, input int run_t, input bit meddle,
                          output int len, output int run_len, output int dones);
      bus.mode  = m;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("fill_phase", phase, 1);
      check("fill_time",  time_left, 3);
      len = 0; run_len = 0; dones = 0;
      while (!bus.idle && len < 200) begin
         if (phase == 3'd2) begin
            run_len++;
            if (run_len == 1) check("run_load", time_left, run_t);
         end
         if (meddle && phase == 3'd2 && run_len == 3) begin
            bus.mode  = 2'b11;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         len++;
         step();
         if (cycle_done) dones++;
      end
      check("cycle_finished", bus.idle, 1);
      step();
      check("done_one_cycle", cycle_done, 0);
   endtask

   initial begin
      int len, run_len, dones, wait_n;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.mode  = 2'b00;
`ifdef CYCLE_PAUSE_EN
      bus.pause = 1'b0;
`endif
      step();
      step();
      chk_en = 1'b1;
      check("rst_phase", phase, 0);
      check("rst_idle",  bus.idle, 1);
      check("rst_tl",    time_left, 0);
      rst = 1'b0;
      step();

      // 1. low mode: 11 ticks
      run_one(2'b01, 4, 1'b0, len, run_len, dones);
      check("low_len",   len, 44);
      check("low_run",   run_len, 16);
      check("low_dones", dones, 1);

      // 2. high and normal modes
      run_one(2'b11, 8, 1'b0, len, run_len, dones);
      check("high_len", len, 60);
      run_one(2'b10, 6, 1'b0, len, run_len, dones);
      check("norm_len", len, 52);

      // 3. start with invalid mode
      bus.mode  = 2'b00;
      bus.start = 1'b1;
      repeat (20) step();
      check("inv_phase", phase, 0);
      check("inv_idle",  bus.idle, 1);
      bus.start = 1'b0;
      step();

      // 4. mode change and start pulse during RUN are ignored
      run_one(2'b01, 4, 1'b1, len, run_len, dones);
      check("frz_run",   run_len, 16);
      check("frz_len",   len, 44);
      bus.mode = 2'b01;
      step();

      // 5. reset during DRAIN
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_n = 0;
      while (phase != 3'd3 && wait_n < 100) begin
         wait_n++;
         step();
      end
      check("reach_drain", phase, 3);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_phase", phase, 0);
      check("mrst_tl",    time_left, 0);
      check("mrst_mode",  run_mode, 0);
      check("mrst_done",  cycle_done, 0);
      dones = 0;
      repeat (30) begin
         step();
         if (cycle_done) dones++;
      end
      check("mrst_nodone", dones, 0);

`ifdef CYCLE_PAUSE_EN
      // 6. pause 10 clocks in FILL
      begin
         logic [7:0] tl_hold;
         bus.mode  = 2'b01;
         bus.start = 1'b1;
         step();
         bus.start = 1'b0;
         len = 0;
         step(); step(); len += 2;
         bus.pause = 1'b1;
         tl_hold = time_left;
         repeat (10) begin
            step();
            len++;
            check("pause_phase", phase, 1);
            check("pause_tl",    time_left, tl_hold);
         end
         bus.pause = 1'b0;
         while (!bus.idle && len < 200) begin
            len++;
            step();
         end
         check("pause_len", len, 54);
         step();
      end
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 299) == 0);
         bus.start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) bus.mode = 2'($urandom_range(0, 3));
`ifdef CYCLE_PAUSE_EN
         bus.pause = ($urandom_range(0, 4) == 0);
`endif
         step();
      end
      rst       = 1'b0;
      bus.start = 1'b0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
